// File: rtl/ed25519_ecc_seq_pkg.sv
// Shared widths, instruction/tag payloads and FSM encoding for the ECC issue sequencer.
package ed25519_ecc_seq_pkg;

    localparam int unsigned W_D     = 256;
    localparam int unsigned W_M     = 128;
    localparam int unsigned N_REG   = 32;
    localparam int unsigned W_R     = $clog2(N_REG);
    localparam int unsigned W_PC    = 10;
    localparam int unsigned W_OP    = 5;
    localparam int unsigned W_TAG   = W_R + 1;
    localparam int unsigned ALU_LAT = 20;

    localparam logic [W_OP-1:0] OP_HALT = 5'h1F;

    typedef struct packed {
        logic [W_OP-1:0] op;
        logic [W_R-1:0]  dst;
        logic [W_R-1:0]  src_a;
        logic [W_R-1:0]  src_b;
        logic [W_R-1:0]  src_c;
        logic [6:0]      rsvd;
    } insn_t;

    typedef struct packed {
        logic           valid;
        logic [W_R-1:0] dst;
    } tag_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ed25519_ecc_scoreboard.sv
// Per-register pending bits for in-flight ALU results; answers the RAW/WAW hazard query.
module ed25519_ecc_scoreboard
    import ed25519_ecc_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           set_i,
    input  logic [W_R-1:0] set_idx_i,
    input  logic           clr_i,
    input  logic [W_R-1:0] clr_idx_i,
    input  logic [W_R-1:0] q_a_i,
    input  logic [W_R-1:0] q_b_i,
    input  logic [W_R-1:0] q_c_i,
    input  logic [W_R-1:0] q_d_i,
    output logic           hazard_c_o,
    output logic           empty_c_o
);

    logic [N_REG-1:0] pending_q;
    logic [N_REG-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_i) pending_d[clr_idx_i] = 1'b0;
        if (set_i) pending_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    // Query reads the registered bits: a writeback this cycle only frees the register next cycle.
    assign hazard_c_o = pending_q[q_a_i] | pending_q[q_b_i] | pending_q[q_c_i] | pending_q[q_d_i];
    assign empty_c_o  = (pending_q == '0);

endmodule

// File: rtl/ed25519_ecc_sequencer.sv
// Issue side of the sigverify ECC ALU: runs microcode over a local register file.
// Build with ECC_SEQ_PERF_EN defined to add issue/stall performance counters.
module ed25519_ecc_sequencer
    import ed25519_ecc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ld_valid,
    input  logic [W_R-1:0]  i_ld_addr,
    input  logic [W_D-1:0]  i_ld_data,
    input  logic            i_start,
    input  logic [W_PC-1:0] i_start_pc,
    output logic            o_busy,
    output logic            o_done,
    input  logic [W_R-1:0]  i_rd_addr,
    output logic [W_D-1:0]  o_rd_data,
    output logic [W_PC-1:0] o_pc,
    input  logic [31:0]     i_insn,
    output logic [W_OP-1:0] o_alu_o,
    output logic [W_D-1:0]  o_alu_a,
    output logic [W_D-1:0]  o_alu_b,
    output logic            o_alu_c,
    output logic [W_M-1:0]  o_alu_m,
`ifdef ECC_SEQ_PERF_EN
    output logic [31:0]     o_perf_issue,
    output logic [31:0]     o_perf_stall,
`endif
    input  logic [W_D-1:0]  i_alu_d,
    input  logic [W_M-1:0]  i_alu_m
);

    localparam int unsigned W_FL = $clog2(ALU_LAT + 1);

    state_e          state_q, state_d;
    logic [W_PC-1:0] pc_q, pc_d;
    logic            held_vld_q, held_vld_d;
    insn_t           held_q;
    logic            busy_q, done_q;
    logic [W_FL-1:0] flush_q;
    logic [W_OP-1:0] alu_o_q;
    logic [W_D-1:0]  alu_a_q, alu_b_q;
    logic            alu_c_q;
    logic [W_M-1:0]  alu_m_q;
    logic [W_D-1:0]  rd_data_q;
    logic [W_D-1:0]  regfile_q [N_REG];

    insn_t           insn_c;
    tag_t            iss_tag_c, wb_tag_c;
    logic            flushing_c, start_acc_c, is_halt_c, hazard_c, sb_empty_c;
    logic            issue_c, stall_c, wb_en_c, ld_en_c, rf_we_c;
    logic [W_R-1:0]  rf_waddr_c;
    logic [W_D-1:0]  rf_wdata_c;
    logic            unused_alu_m_c;

    // A stalled instruction is parked locally since the ROM has already moved on to o_pc.
    assign insn_c      = held_vld_q ? held_q : insn_t'(i_insn);
    assign is_halt_c   = (insn_c.op == OP_HALT);
    assign flushing_c  = (flush_q != '0);
    assign start_acc_c = (state_q == S_IDLE) && i_start && !flushing_c;
    assign issue_c     = (state_q == S_ISSUE) && !is_halt_c && !hazard_c;
    assign stall_c     = (state_q == S_ISSUE) && !is_halt_c && hazard_c;
    assign iss_tag_c   = '{valid: 1'b1, dst: insn_c.dst};
    assign wb_tag_c    = tag_t'(i_alu_m[W_TAG-1:0]);
    assign wb_en_c     = wb_tag_c.valid && !flushing_c && !rst;
    assign ld_en_c     = i_ld_valid && !busy_q && !rst;
    assign unused_alu_m_c = ^i_alu_m[W_M-1:W_TAG];

    always_comb begin
        rf_we_c    = wb_en_c || ld_en_c;
        rf_waddr_c = wb_en_c ? wb_tag_c.dst : i_ld_addr;
        rf_wdata_c = wb_en_c ? i_alu_d : i_ld_data;
    end

    ed25519_ecc_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (issue_c),
        .set_idx_i  (insn_c.dst),
        .clr_i      (wb_en_c),
        .clr_idx_i  (wb_tag_c.dst),
        .q_a_i      (insn_c.src_a),
        .q_b_i      (insn_c.src_b),
        .q_c_i      (insn_c.src_c),
        .q_d_i      (insn_c.dst),
        .hazard_c_o (hazard_c),
        .empty_c_o  (sb_empty_c)
    );

    // o_pc runs one ahead of the instruction being evaluated in ISSUE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        held_vld_d = held_vld_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc_c) begin
                    state_d    = S_FETCH;
                    pc_d       = i_start_pc;
                    held_vld_d = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
                pc_d    = pc_q + W_PC'(1);
            end
            S_ISSUE: begin
                if (is_halt_c) begin
                    state_d = S_DRAIN;
                end else if (issue_c) begin
                    pc_d       = pc_q + W_PC'(1);
                    held_vld_d = 1'b0;
                end else begin
                    held_vld_d = 1'b1;
                end
            end
            S_DRAIN: if (sb_empty_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            held_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flush_q    <= W_FL'(ALU_LAT);
            alu_o_q    <= '0;
            alu_m_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            held_vld_q <= held_vld_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            alu_m_q    <= issue_c ? W_M'(iss_tag_c) : '0;
            if (issue_c)    alu_o_q <= insn_c.op;
            if (flushing_c) flush_q <= flush_q - W_FL'(1);
            rd_data_q  <= regfile_q[i_rd_addr];
        end
    end

    // Datapath state is not reset; the tag and flush logic make stale contents harmless.
    always_ff @(posedge clk) begin
        if (stall_c) held_q <= insn_c;
        if (issue_c) begin
            alu_a_q <= regfile_q[insn_c.src_a];
            alu_b_q <= regfile_q[insn_c.src_b];
            alu_c_q <= regfile_q[insn_c.src_c][0];
        end
        if (rf_we_c) regfile_q[rf_waddr_c] <= rf_wdata_c;
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_pc      = pc_q;
    assign o_rd_data = rd_data_q;
    assign o_alu_o   = alu_o_q;
    assign o_alu_a   = alu_a_q;
    assign o_alu_b   = alu_b_q;
    assign o_alu_c   = alu_c_q;
    assign o_alu_m   = alu_m_q;

`ifdef ECC_SEQ_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc_c) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue_c && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 32'd1;
            if (stall_c && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign o_perf_issue = perf_issue_q;
    assign o_perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ed25519_ecc_sequencer.sv
// Self-checking bench: ROM + fixed-latency ALU model, issue scoreboard queue, timing checks.
module tb_ed25519_ecc_sequencer;
    import ed25519_ecc_seq_pkg::*;

    localparam logic [W_OP-1:0] OP_ADD = 5'h01;
    localparam logic [W_OP-1:0] OP_MUL = 5'h02;
    localparam logic [W_OP-1:0] OP_XOR = 5'h03;

    typedef struct packed {
        logic [W_OP-1:0] op;
        logic [W_R-1:0]  dst;
        logic [W_D-1:0]  a;
        logic [W_D-1:0]  b;
        logic            c;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_ld_valid;
    logic [W_R-1:0]  i_ld_addr;
    logic [W_D-1:0]  i_ld_data;
    logic            i_start;
    logic [W_PC-1:0] i_start_pc;
    logic            o_busy, o_done;
    logic [W_R-1:0]  i_rd_addr;
    logic [W_D-1:0]  o_rd_data;
    logic [W_PC-1:0] o_pc;
    logic [31:0]     i_insn;
    logic [W_OP-1:0] o_alu_o;
    logic [W_D-1:0]  o_alu_a, o_alu_b;
    logic            o_alu_c;
    logic [W_M-1:0]  o_alu_m;
    logic [W_D-1:0]  i_alu_d;
    logic [W_M-1:0]  i_alu_m;
`ifdef ECC_SEQ_PERF_EN
    logic [31:0]     o_perf_issue, o_perf_stall;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q [$];
    int   issue_t_q [$];
    logic [31:0] rom [1024];

    ed25519_ecc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .i_ld_valid (i_ld_valid),
        .i_ld_addr  (i_ld_addr),
        .i_ld_data  (i_ld_data),
        .i_start    (i_start),
        .i_start_pc (i_start_pc),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_pc       (o_pc),
        .i_insn     (i_insn),
        .o_alu_o    (o_alu_o),
        .o_alu_a    (o_alu_a),
        .o_alu_b    (o_alu_b),
        .o_alu_c    (o_alu_c),
        .o_alu_m    (o_alu_m),
`ifdef ECC_SEQ_PERF_EN
        .o_perf_issue (o_perf_issue),
        .o_perf_stall (o_perf_stall),
`endif
        .i_alu_d    (i_alu_d),
        .i_alu_m    (i_alu_m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data for o_pc appears one cycle later.
    always @(posedge clk) i_insn <= rom[o_pc];

    function automatic logic [W_D-1:0] alu_fn(input logic [W_OP-1:0] op, input logic [W_D-1:0] a,
                                              input logic [W_D-1:0] b, input logic c);
        case (op)
            OP_ADD:  return a + b;
            OP_MUL:  return a * b;
            OP_XOR:  return a ^ b;
            default: return c ? a : b;
        endcase
    endfunction

    // ALU: ALU_LAT cycles counted from the sequencer's issue register, so ALU_LAT-1 stages here.
    logic [W_M-1:0] pm [ALU_LAT-1];
    logic [W_D-1:0] pd [ALU_LAT-1];
    always @(posedge clk) begin
        pm[0] <= o_alu_m;
        pd[0] <= alu_fn(o_alu_o, o_alu_a, o_alu_b, o_alu_c);
        for (int k = 1; k < ALU_LAT - 1; k++) begin
            pm[k] <= pm[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign i_alu_m = pm[ALU_LAT-2];
    assign i_alu_d = pd[ALU_LAT-2];

    task automatic check_val(input string tag, input logic [W_D-1:0] got, input logic [W_D-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_alu_m[W_TAG-1]) begin
            issue_t_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_val("unexp_issue", W_D'(o_alu_m[W_R-1:0]), W_D'(5'h1F) + W_D'(1));
            end else begin
                e = exp_q.pop_front();
                check_val("iss_op",  W_D'(o_alu_o), W_D'(e.op));
                check_val("iss_dst", W_D'(o_alu_m[W_R-1:0]), W_D'(e.dst));
                check_val("iss_mhi", W_D'(o_alu_m[W_M-1:W_TAG]), '0);
                check_val("iss_a",   o_alu_a, e.a);
                check_val("iss_b",   o_alu_b, e.b);
                check_val("iss_c",   W_D'(o_alu_c), W_D'(e.c));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [W_OP-1:0] op, input logic [W_R-1:0] d,
                                       input logic [W_R-1:0] a, input logic [W_R-1:0] b,
                                       input logic [W_R-1:0] c);
        return {op, d, a, b, c, 7'd0};
    endfunction

    task automatic expect_iss(input logic [W_OP-1:0] op, input logic [W_R-1:0] d,
                              input logic [W_D-1:0] a, input logic [W_D-1:0] b, input logic c);
        exp_t e;
        e.op = op; e.dst = d; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic ld(input logic [W_R-1:0] addr, input logic [W_D-1:0] data);
        i_ld_valid = 1'b1; i_ld_addr = addr; i_ld_data = data;
        @(negedge clk);
        i_ld_valid = 1'b0;
    endtask

    task automatic rd(input logic [W_R-1:0] addr, output logic [W_D-1:0] val);
        i_rd_addr = addr;
        @(negedge clk);
        val = o_rd_data;
    endtask

    // Must be called on the negedge at which rst was dropped.
    task automatic flush_check(input string tag);
        bit seen = 1'b0;
        i_start_pc = 10'h050;
        i_start    = 1'b1;
        repeat (ALU_LAT) begin
            @(negedge clk);
            if (o_busy) seen = 1'b1;
        end
        i_start = 1'b0;
        check_val(tag, W_D'(seen), '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Start a program and wait for done; poke injects a host load and restart attempt while busy.
    task automatic run_prog(input logic [W_PC-1:0] pc, input bit poke, output int t_start, output int t_done);
        i_start_pc = pc;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t_start = cyc;
        t_done  = -1;
        check_val("busy_on", W_D'(o_busy), W_D'(1));
        for (int k = 0; k < 200; k++) begin
            if (o_done) begin
                t_done = cyc;
                break;
            end
            if (poke && k == 4) begin
                i_ld_valid = 1'b1; i_ld_addr = 5'd1; i_ld_data = W_D'(7);
                i_start = 1'b1; i_start_pc = 10'h050;
            end
            if (poke && k == 5) begin
                i_ld_valid = 1'b0; i_start = 1'b0;
            end
            @(negedge clk);
        end
        check_val("done_seen", W_D'(t_done >= 0), W_D'(1));
        @(negedge clk);
        check_val("busy_off", W_D'(o_busy), '0);
        check_val("done_pulse", W_D'(o_done), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_s, t_d, n0;
        logic [W_D-1:0] v;

        for (int k = 0; k < 1024; k++) rom[k] = {OP_HALT, 27'd0};
        i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_data = '0;
        i_start = 1'b0; i_start_pc = '0; i_rd_addr = '0;

        // Reset values and post-reset start blocking
        repeat (3) @(negedge clk);
        check_val("rst_busy",  W_D'(o_busy), '0);
        check_val("rst_done",  W_D'(o_done), '0);
        check_val("rst_pc",    W_D'(o_pc), '0);
        check_val("rst_alu_m", W_D'(o_alu_m), '0);
        check_val("rst_alu_o", W_D'(o_alu_o), '0);
        check_val("rst_rd",    o_rd_data, '0);
        rst = 1'b0;
        flush_check("flush_start_ign0");

        ld(5'd0, '0); ld(5'd1, W_D'(3)); ld(5'd2, W_D'(5)); ld(5'd5, W_D'(1));
        rd(5'd1, v);
        check_val("rd_r1", v, W_D'(3));

        // Single multiply then HALT
        rom[10'h010] = mk(OP_MUL, 5'd3, 5'd1, 5'd2, 5'd0);
        n0 = issue_t_q.size();
        expect_iss(OP_MUL, 5'd3, W_D'(3), W_D'(5), 1'b0);
        run_prog(10'h010, 1'b0, t_s, t_d);
        check_val("mul_lat", W_D'(t_d - t_s), W_D'(ALU_LAT + 3));
        check_val("mul_nissue", W_D'(issue_t_q.size() - n0), W_D'(1));
        rd(5'd3, v);
        check_val("mul_r3", v, W_D'(15));

        // Dependent chain stalls until the writeback lands
        rom[10'h020] = mk(OP_ADD, 5'd3, 5'd1, 5'd2, 5'd0);
        rom[10'h021] = mk(OP_ADD, 5'd4, 5'd3, 5'd1, 5'd0);
        n0 = issue_t_q.size();
        expect_iss(OP_ADD, 5'd3, W_D'(3), W_D'(5), 1'b0);
        expect_iss(OP_ADD, 5'd4, W_D'(8), W_D'(3), 1'b0);
        run_prog(10'h020, 1'b0, t_s, t_d);
        check_val("chain_nissue", W_D'(issue_t_q.size() - n0), W_D'(2));
        check_val("chain_gap", W_D'(issue_t_q[n0+1] - issue_t_q[n0]), W_D'(ALU_LAT + 1));
        rd(5'd4, v);
        check_val("chain_r4", v, W_D'(11));
`ifdef ECC_SEQ_PERF_EN
        check_val("chain_stall", W_D'(o_perf_stall), W_D'(ALU_LAT));
        check_val("chain_pissue", W_D'(o_perf_issue), W_D'(2));
`endif

        // Eight independent ops across the PC wrap point
        for (int i = 0; i < 8; i++) begin
            rom[(10'h3FC + 10'(i)) % 1024] =
                mk((i % 2 == 0) ? OP_ADD : OP_XOR, 5'(8 + i), 5'd1, 5'd2, (i % 2 == 0) ? 5'd0 : 5'd5);
            expect_iss((i % 2 == 0) ? OP_ADD : OP_XOR, 5'(8 + i), W_D'(3), W_D'(5), (i % 2) != 0);
        end
        n0 = issue_t_q.size();
        run_prog(10'h3FC, 1'b0, t_s, t_d);
        check_val("ind_nissue", W_D'(issue_t_q.size() - n0), W_D'(8));
        check_val("ind_span", W_D'(issue_t_q[n0+7] - issue_t_q[n0]), W_D'(7));
        rd(5'd8, v);
        check_val("ind_r8", v, W_D'(8));
        rd(5'd15, v);
        check_val("ind_r15", v, W_D'(6));
`ifdef ECC_SEQ_PERF_EN
        check_val("ind_pissue", W_D'(o_perf_issue), W_D'(8));
        check_val("ind_pstall", W_D'(o_perf_stall), '0);
`endif

        // HALT as the first instruction
        n0 = issue_t_q.size();
        run_prog(10'h050, 1'b0, t_s, t_d);
        check_val("halt_lat", W_D'(t_d - t_s), W_D'(3));
        check_val("halt_nissue", W_D'(issue_t_q.size() - n0), '0);

        // Host load and restart attempts while busy are ignored
        n0 = issue_t_q.size();
        expect_iss(OP_ADD, 5'd3, W_D'(3), W_D'(5), 1'b0);
        expect_iss(OP_ADD, 5'd4, W_D'(8), W_D'(3), 1'b0);
        run_prog(10'h020, 1'b1, t_s, t_d);
        check_val("poke_lat", W_D'(t_d - t_s), W_D'(2 * ALU_LAT + 4));
        check_val("poke_nissue", W_D'(issue_t_q.size() - n0), W_D'(2));
        rd(5'd1, v);
        check_val("poke_r1", v, W_D'(3));
        check_val("poke_norestart", W_D'(o_busy), '0);

        // Reset in the middle of a chain discards in-flight results
        ld(5'd3, W_D'(32'h55)); ld(5'd4, W_D'(32'h66));
        n0 = issue_t_q.size();
        expect_iss(OP_ADD, 5'd3, W_D'(3), W_D'(5), 1'b0);
        i_start_pc = 10'h020;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_nissue", W_D'(issue_t_q.size() - n0), W_D'(1));
        do_reset(2);
        flush_check("flush_start_ign1");
        repeat (4) @(negedge clk);
        check_val("mid_busy", W_D'(o_busy), '0);
        rd(5'd3, v);
        check_val("mid_r3", v, W_D'(32'h55));
        rd(5'd4, v);
        check_val("mid_r4", v, W_D'(32'h66));

        // Scoreboard must be clear again: r3 is immediately issuable
        expect_iss(OP_MUL, 5'd3, W_D'(3), W_D'(5), 1'b0);
        run_prog(10'h010, 1'b0, t_s, t_d);
        check_val("post_lat", W_D'(t_d - t_s), W_D'(ALU_LAT + 3));
        rd(5'd3, v);
        check_val("post_r3", v, W_D'(15));

        check_val("exp_q_left", W_D'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
